multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore state machine controller for the multicycle MIPS datapath.
- Decodes the 6-bit instruction opcode into per-cycle datapath controls.
- Produces the 4-bit ALUop consumed by the ALU control decoder. ALUop = 4'b1111 tells that decoder to use the R-type function field; any other value is passed through as a direct ALU operation code.
- Sits between the instruction register and the datapath. Waits on a memory-ready handshake for all memory accesses.

Parameters:
- None. ALU codes come from the shared ALU header: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, ADDU 1000, XOR 1010, LUI 1110. FUNC (use function field) is 1111.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- Opcode  input  6  instruction opcode from the instruction register; stable after FETCH.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory has completed the current read or write this cycle.
- ALUop  output  4  ALU operation, or 1111 for R-type.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- SignExtend  output  1  1 = sign-extend the immediate, 0 = zero-extend.
- PCWrite  output  1  load PC.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- IorD  output  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load instruction register.
- RegDst  output  1  1 = rd, 0 = rt.
- MemtoReg  output  1  1 = memory data register, 0 = ALUOut.
- RegWrite  output  1  register file write.
- Illegal  output  1  unsupported opcode detected.
- State  output  4  current state, for debug.

Behaviour:
- Outputs are purely a function of State, plus Opcode, Zero and MemReady where noted.
- Unlisted outputs are 0 in every state. ALUop defaults to ADD.
- State register resets asynchronously to FETCH (0).
- While Reset_L = 0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=ADD, PCSource=00. IRWrite=PCWrite=MemReady. Hold while MemReady=0; go to DECODE when MemReady=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUop=ADD, SignExtend=1 (branch target into ALUOut). Next state by opcode:
  - 000000 → RTYPEEX
  - 100011 (LW) or 101011 (SW) → MEMADR
  - 000100 (BEQ) → BRANCH
  - 000010 (J) → JUMP
  - 001000 / 001001 / 001100 / 001101 / 001010 / 001110 / 001111 → ITYPEEX
  - any other opcode: Illegal=1 for this single cycle, next state FETCH; no register or memory write occurs.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, SignExtend=1, ALUop=ADD. LW → MEMRD, SW → MEMWR.
- MEMRD (3): MemRead=1, IorD=1. Hold until MemReady=1, then MEMWB.
- MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEMWR (5): MemWrite=1, IorD=1. Hold until MemReady=1, then FETCH. MemWrite stays high for every stall cycle.
- RTYPEEX (6): ALUSrcA=1, ALUSrcB=00, ALUop=1111. Next RTYPEWB.
- RTYPEWB (7): RegDst=1, MemtoReg=0, RegWrite=1, ALUop=1111. Next FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUop=SUB, PCSource=01, PCWrite=Zero. Next FETCH.
- JUMP (9): PCSource=10, PCWrite=1. Next FETCH.
- ITYPEEX (10): ALUSrcA=1, ALUSrcB=10. ALUop and SignExtend by opcode:
  - ADDI → ADD, SE=1
  - ADDIU → ADDU, SE=1
  - SLTI → SLT, SE=1
  - ANDI → AND, SE=0
  - ORI → OR, SE=0
  - XORI → XOR, SE=0
  - LUI → LUI, SE=0
  - Next ITYPEWB.
- ITYPEWB (11): RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- Unused encodings 12–15 go to FETCH next cycle with all write enables 0.
- Cycle counts with no memory stall: LW 5, SW/R/I 4, BEQ/J 3. Each MemReady=0 cycle adds one cycle.
- Reset asserted in any state, including mid-stall: State goes to FETCH immediately and write enables drop in the same cycle.

Test Plan:
- Reset_L=0 for 2 cycles, then release with MemReady=1, Opcode=000000 → State sequence 0,1,6,7,0. ALUop=1111 in states 6 and 7. RegWrite=1 and RegDst=1 only in state 7.
- LW (100011), MemReady low for 2 cycles in FETCH and 3 cycles in MEMRD → FETCH lasts 3 cycles with IRWrite=0 until the last. MEMRD lasts 4 cycles. MEMWB has MemtoReg=1, RegWrite=1. Total 10 cycles.
- BEQ (000100), Zero=1, then repeat with Zero=0 → in state 8, ALUop=0110, PCSource=01, PCWrite=1 (first run) or 0 (second run).
- ANDI (001100) then SLTI (001010) → in state 10: ALUop=0000, SignExtend=0 for ANDI; ALUop=0111, SignExtend=1 for SLTI.
- Opcode=111111 → Illegal=1 for exactly one cycle in DECODE, then FETCH. RegWrite and MemWrite never assert.
- SW with MemReady=0 held in MEMWR, then Reset_L pulsed low mid-stall → MemWrite drops to 0 asynchronously and State=0 before the next CLK edge.

Source files
------------

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bundle between the multicycle controller and the MIPS datapath
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic [3:0] ALUop;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       SignExtend;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       Illegal;
    logic [3:0] State;

    modport slave (
        input  Opcode, Zero, MemReady,
        output ALUop, ALUSrcA, ALUSrcB, SignExtend, PCWrite, PCSource, IorD,
               MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Illegal, State
    );

    modport master (
        output Opcode, Zero, MemReady,
        input  ALUop, ALUSrcA, ALUSrcB, SignExtend, PCWrite, PCSource, IorD,
               MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Illegal, State
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore controller for the multicycle MIPS datapath
module multicycle_control (
    input  logic                        CLK,
    input  logic                        Reset_L,
    multicycle_control_if.slave         bus
);
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1110;
    localparam logic [3:0] ALU_FUNC = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ITYPEEX = 4'd10,
        S_ITYPEWB = 4'd11
    } state_t;

    state_t r_state;
    logic   w_is_itype;
    logic   w_pc_write;
    logic   w_ir_write;
    logic   w_mem_write;
    logic   w_reg_write;

    always_comb begin
        w_is_itype = 1'b0;
        case (bus.Opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_is_itype = 1'b1;
            default:                                                     w_is_itype = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:   if (bus.MemReady) r_state <= S_DECODE;
                S_DECODE: begin
                    if (bus.Opcode == OP_RTYPE)                          r_state <= S_RTYPEEX;
                    else if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) r_state <= S_MEMADR;
                    else if (bus.Opcode == OP_BEQ)                       r_state <= S_BRANCH;
                    else if (bus.Opcode == OP_J)                         r_state <= S_JUMP;
                    else if (w_is_itype)                                 r_state <= S_ITYPEEX;
                    else                                                 r_state <= S_FETCH;
                end
                S_MEMADR: begin
                    if (bus.Opcode == OP_LW)      r_state <= S_MEMRD;
                    else if (bus.Opcode == OP_SW) r_state <= S_MEMWR;
                    else                          r_state <= S_FETCH;
                end
                S_MEMRD:   if (bus.MemReady) r_state <= S_MEMWB;
                S_MEMWB:   r_state <= S_FETCH;
                S_MEMWR:   if (bus.MemReady) r_state <= S_FETCH;
                S_RTYPEEX: r_state <= S_RTYPEWB;
                S_RTYPEWB: r_state <= S_FETCH;
                S_BRANCH:  r_state <= S_FETCH;
                S_JUMP:    r_state <= S_FETCH;
                S_ITYPEEX: r_state <= S_ITYPEWB;
                S_ITYPEWB: r_state <= S_FETCH;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.ALUop      = ALU_ADD;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.SignExtend = 1'b0;
        bus.PCSource   = 2'b00;
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.Illegal    = 1'b0;
        w_pc_write     = 1'b0;
        w_ir_write     = 1'b0;
        w_mem_write    = 1'b0;
        w_reg_write    = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                w_ir_write  = bus.MemReady;
                w_pc_write  = bus.MemReady;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                bus.ALUSrcB    = 2'b11;
                bus.SignExtend = 1'b1;
                bus.Illegal    = !(bus.Opcode == OP_RTYPE || bus.Opcode == OP_LW ||
                                   bus.Opcode == OP_SW || bus.Opcode == OP_BEQ ||
                                   bus.Opcode == OP_J || w_is_itype);
            end
            S_MEMADR: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.SignExtend = 1'b1;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                w_reg_write  = 1'b1;
            end
            S_MEMWR: begin
                bus.IorD    = 1'b1;
                w_mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUop   = ALU_FUNC;
            end
            S_RTYPEWB: begin
                bus.RegDst  = 1'b1;
                bus.ALUop   = ALU_FUNC;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUop    = ALU_SUB;
                bus.PCSource = 2'b01;
                w_pc_write   = bus.Zero;
            end
            S_JUMP: begin
                bus.PCSource = 2'b10;
                w_pc_write   = 1'b1;
            end
            S_ITYPEEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (bus.Opcode)
                    OP_ADDI:  begin bus.ALUop = ALU_ADD;  bus.SignExtend = 1'b1; end
                    OP_ADDIU: begin bus.ALUop = ALU_ADDU; bus.SignExtend = 1'b1; end
                    OP_SLTI:  begin bus.ALUop = ALU_SLT;  bus.SignExtend = 1'b1; end
                    OP_ANDI:  bus.ALUop = ALU_AND;
                    OP_ORI:   bus.ALUop = ALU_OR;
                    OP_XORI:  bus.ALUop = ALU_XOR;
                    OP_LUI:   bus.ALUop = ALU_LUI;
                    default:  bus.ALUop = ALU_ADD;
                endcase
            end
            S_ITYPEWB: w_reg_write = 1'b1;
            default: ;
        endcase
    end

    // Reset also masks the write strobes combinationally, not just via the state register
    assign bus.PCWrite  = w_pc_write  & Reset_L;
    assign bus.IRWrite  = w_ir_write  & Reset_L;
    assign bus.MemWrite = w_mem_write & Reset_L;
    assign bus.RegWrite = w_reg_write & Reset_L;
    assign bus.State    = r_state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
    logic CLK = 1'b0;
    logic Reset_L = 1'b0;
    always #5 CLK = ~CLK;

    multicycle_control_if bus_if ();
    multicycle_control u_dut (.CLK(CLK), .Reset_L(Reset_L), .bus(bus_if));

    int n_vec = 0;
    int n_bad = 0;

    typedef enum int {C_R, C_LW, C_SW, C_BEQ, C_J, C_I, C_ILL} cls_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        logic [3:0] st;
        logic [3:0] aluop;
        logic       se;
        logic       pcw;
        logic [1:0] pcs;
    } vec_t;

    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'b000000: return C_R;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            6'b001000, 6'b001001, 6'b001010, 6'b001100,
            6'b001101, 6'b001110, 6'b001111: return C_I;
            default:   return C_ILL;
        endcase
    endfunction

    // {ALUop, SrcA, SrcB, SE, PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Illegal, State}
    function automatic logic [22:0] got_out();
        return {bus_if.ALUop, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.SignExtend, bus_if.PCWrite,
                bus_if.PCSource, bus_if.IorD, bus_if.MemRead, bus_if.MemWrite, bus_if.IRWrite,
                bus_if.RegDst, bus_if.MemtoReg, bus_if.RegWrite, bus_if.Illegal, bus_if.State};
    endfunction

    function automatic logic [22:0] exp_out(input int st, input logic [5:0] op, input logic z,
                                            input logic mr, input logic rstn);
        logic [3:0] alu = 4'b0010;
        logic sa = 0, se = 0, pcw = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rd = 0, m2r = 0, rw = 0, ill = 0;
        logic [1:0] sb = 2'b00, pcs = 2'b00;
        cls_t c = classify(op);
        if (st == 0) begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
        if (st == 1) begin sb = 2'b11; se = 1; ill = (c == C_ILL); end
        if (st == 2) begin sa = 1; sb = 2'b10; se = 1; end
        if (st == 3) begin mrd = 1; iord = 1; end
        if (st == 4) begin m2r = 1; rw = 1; end
        if (st == 5) begin mwr = 1; iord = 1; end
        if (st == 6 || st == 7) alu = 4'b1111;
        if (st == 6) sa = 1;
        if (st == 7) begin rd = 1; rw = 1; end
        if (st == 8) begin sa = 1; alu = 4'b0110; pcs = 2'b01; pcw = z; end
        if (st == 9) begin pcs = 2'b10; pcw = 1; end
        if (st == 10) begin
            sa = 1; sb = 2'b10;
            // ALU code and extension mode looked up from the immediate-op table
            case (op[2:0])
                3'd0: begin alu = 4'b0010; se = 1; end
                3'd1: begin alu = 4'b1000; se = 1; end
                3'd2: begin alu = 4'b0111; se = 1; end
                3'd4: alu = 4'b0000;
                3'd5: alu = 4'b0001;
                3'd6: alu = 4'b1010;
                default: alu = 4'b1110;
            endcase
        end
        if (st == 11) rw = 1;
        if (!rstn) begin pcw = 0; irw = 0; mwr = 0; rw = 0; end
        return {alu, sa, sb, se, pcw, pcs, iord, mrd, mwr, irw, rd, m2r, rw, ill, st[3:0]};
    endfunction

    task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (state got %0d exp %0d)", name, got, exp, got[3:0], exp[3:0]);
        end
    endtask

    // Entered at posedge+1; drives one cycle's inputs, checks mid-cycle, advances one edge
    task automatic cycle(input string name, input int st, input logic [5:0] op, input logic z, input logic mr);
        bus_if.Opcode = op; bus_if.Zero = z; bus_if.MemReady = mr;
        #3;
        check(name, got_out(), exp_out(st, op, z, mr, Reset_L));
        @(posedge CLK); #1;
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                             input int fstall, input int mstall);
        int sq[$];
        logic mq[$];
        cls_t c = classify(op);
        for (int i = 0; i < fstall; i++) begin sq.push_back(0); mq.push_back(1'b0); end
        sq.push_back(0); mq.push_back(1'b1);
        sq.push_back(1); mq.push_back(1'($urandom));
        case (c)
            C_R:   begin sq.push_back(6); mq.push_back(1'($urandom)); sq.push_back(7); mq.push_back(1'($urandom)); end
            C_LW, C_SW: begin
                sq.push_back(2); mq.push_back(1'($urandom));
                for (int i = 0; i < mstall; i++) begin sq.push_back(c == C_LW ? 3 : 5); mq.push_back(1'b0); end
                sq.push_back(c == C_LW ? 3 : 5); mq.push_back(1'b1);
                if (c == C_LW) begin sq.push_back(4); mq.push_back(1'($urandom)); end
            end
            C_BEQ: begin sq.push_back(8); mq.push_back(1'($urandom)); end
            C_J:   begin sq.push_back(9); mq.push_back(1'($urandom)); end
            C_I:   begin sq.push_back(10); mq.push_back(1'($urandom)); sq.push_back(11); mq.push_back(1'($urandom)); end
            default: ;
        endcase
        foreach (sq[i]) cycle(name, sq[i], op, z, mq[i]);
    endtask

    vec_t tbl[13];
    logic [5:0] legal_ops[12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000,
                                  6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111};

    initial begin
        int lw_cycles;
        int guard;
        tbl[0]  = '{6'b001000, 1'b0, 4'd10, 4'b0010, 1'b1, 1'b0, 2'b00};
        tbl[1]  = '{6'b001001, 1'b0, 4'd10, 4'b1000, 1'b1, 1'b0, 2'b00};
        tbl[2]  = '{6'b001010, 1'b0, 4'd10, 4'b0111, 1'b1, 1'b0, 2'b00};
        tbl[3]  = '{6'b001100, 1'b0, 4'd10, 4'b0000, 1'b0, 1'b0, 2'b00};
        tbl[4]  = '{6'b001101, 1'b0, 4'd10, 4'b0001, 1'b0, 1'b0, 2'b00};
        tbl[5]  = '{6'b001110, 1'b1, 4'd10, 4'b1010, 1'b0, 1'b0, 2'b00};
        tbl[6]  = '{6'b001111, 1'b0, 4'd10, 4'b1110, 1'b0, 1'b0, 2'b00};
        tbl[7]  = '{6'b000100, 1'b1, 4'd8,  4'b0110, 1'b0, 1'b1, 2'b01};
        tbl[8]  = '{6'b000100, 1'b0, 4'd8,  4'b0110, 1'b0, 1'b0, 2'b01};
        tbl[9]  = '{6'b000010, 1'b0, 4'd9,  4'b0010, 1'b0, 1'b1, 2'b10};
        tbl[10] = '{6'b000000, 1'b1, 4'd6,  4'b1111, 1'b0, 1'b0, 2'b00};
        tbl[11] = '{6'b100011, 1'b0, 4'd2,  4'b0010, 1'b1, 1'b0, 2'b00};
        tbl[12] = '{6'b101011, 1'b0, 4'd2,  4'b0010, 1'b1, 1'b0, 2'b00};

        bus_if.Opcode = 6'b000000; bus_if.Zero = 1'b0; bus_if.MemReady = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 2; i++) cycle("reset", 0, 6'b000000, 1'b0, 1'b1);
        Reset_L = 1'b1;

        run_instr("rtype", 6'b000000, 1'b0, 0, 0);

        lw_cycles = 0;
        run_instr("lw_stall", 6'b100011, 1'b0, 2, 3);
        for (int i = 0; i < 1; i++) lw_cycles = n_vec;
        run_instr("beq_z1", 6'b000100, 1'b1, 0, 0);
        run_instr("beq_z0", 6'b000100, 1'b0, 0, 0);
        run_instr("andi", 6'b001100, 1'b0, 0, 0);
        run_instr("slti", 6'b001010, 1'b0, 0, 0);
        run_instr("illegal", 6'b111111, 1'b0, 0, 0);

        // SW stalled in MEMWR, reset pulsed between clock edges
        cycle("sw_rst", 0, 6'b101011, 1'b0, 1'b1);
        cycle("sw_rst", 1, 6'b101011, 1'b0, 1'b1);
        cycle("sw_rst", 2, 6'b101011, 1'b0, 1'b0);
        cycle("sw_rst", 5, 6'b101011, 1'b0, 1'b0);
        bus_if.MemReady = 1'b0;
        #1;
        check("sw_stall_memwrite", {22'd0, bus_if.MemWrite}, 23'd1);
        Reset_L = 1'b0;
        #1;
        check("sw_async_rst", {bus_if.MemWrite, bus_if.RegWrite, bus_if.State}, 6'd0);
        @(posedge CLK); #1;
        Reset_L = 1'b1;
        cycle("post_rst", 0, 6'b000000, 1'b0, 1'b0);

        // Table of key-state outputs: fetch, decode, then the first execute-class state
        foreach (tbl[i]) begin
            cycle("tbl_fetch", 0, tbl[i].op, tbl[i].zero, 1'b1);
            cycle("tbl_decode", 1, tbl[i].op, tbl[i].zero, 1'b1);
            bus_if.MemReady = 1'b1;
            #3;
            check($sformatf("tbl%0d", i),
                  {8'd0, bus_if.State, bus_if.ALUop, bus_if.SignExtend, bus_if.PCWrite, bus_if.PCSource},
                  {8'd0, tbl[i].st, tbl[i].aluop, tbl[i].se, tbl[i].pcw, tbl[i].pcs});
            @(posedge CLK); #1;
            guard = 0;
            while (bus_if.State != 4'd0 && guard < 6) begin @(posedge CLK); #1; guard++; end
            if (guard >= 6) begin
                n_vec++; n_bad++;
                $display("FAIL tbl%0d_return: state %0d did not return to 0", i, bus_if.State);
            end
        end

        for (int k = 0; k < 200; k++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 11)];
            run_instr("random", op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        if (lw_cycles < 0) $display("unreachable");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
